// File: rtl/sd_bus_sched.sv
// -----------------------------------------------------------------------------
// sd_bus_sched
//
// Purpose: arbitrates the single SPI link to an SD card between three engines
// (init, read, write). After reset the init engine owns the bus until it
// reports done. Read and write requests are then granted one at a time, with
// round-robin arbitration when both are pending. Each transaction is guarded
// by an owner timeout and followed by a fixed idle gap.
//
// Ports:
//   SD_CK                 clock, all state updates on the rising edge
//   rst_n                 asynchronous active-low reset
//   init_done             init engine finished (level)
//   init_mosi/init_csn    init engine SPI drive
//   rd_req                read request (level, held until serviced)
//   rd_done               read engine finished (1-cycle pulse)
//   rd_mosi/rd_csn        read engine SPI drive
//   wr_req                write request (level)
//   wr_done               write engine finished (pulse)
//   wr_mosi/wr_csn        write engine SPI drive
//   init_en               enables the init engine
//   rd_go/wr_go           1-cycle start pulse, high in the cycle of the grant
//   SD_MOSI/SD_CSn        muxed card SPI lines
//   busy                  low only while idle
//   tmo_err               sticky owner-timeout flag, cleared by the next grant
// -----------------------------------------------------------------------------
module sd_bus_sched #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int GAP_CYC     = 8
) (
    input  logic SD_CK,
    input  logic rst_n,
    input  logic init_done,
    input  logic init_mosi,
    input  logic init_csn,
    input  logic rd_req,
    input  logic rd_done,
    input  logic rd_mosi,
    input  logic rd_csn,
    input  logic wr_req,
    input  logic wr_done,
    input  logic wr_mosi,
    input  logic wr_csn,
    output logic init_en,
    output logic rd_go,
    output logic wr_go,
    output logic SD_MOSI,
    output logic SD_CSn,
    output logic busy,
    output logic tmo_err
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    // Terminal counts. GAP_CYC of 0 still yields a single gap cycle.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] GAP_LAST = 16'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;       // owner cycles in RD/WR, gap cycles in GAP
    logic        last_wr_q, last_wr_d;
    logic        tmo_q, tmo_d;

    always_ff @(posedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            last_wr_q <= 1'b1;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        tmo_d     = tmo_q;
        init_en   = 1'b0;
        rd_go     = 1'b0;
        wr_go     = 1'b0;
        SD_MOSI   = 1'b1;
        SD_CSn    = 1'b1;
        busy      = 1'b1;

        case (state_q)
            S_INIT: begin
                init_en = 1'b1;
                SD_MOSI = init_mosi;
                SD_CSn  = init_csn;
                if (init_done) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end

            S_IDLE: begin
                busy = 1'b0;
                // Read wins when alone, or when both pend and write went last.
                if (rd_req && (!wr_req || last_wr_q)) begin
                    rd_go     = 1'b1;
                    state_d   = S_RD;
                    cnt_d     = '0;
                    last_wr_d = 1'b0;
                    tmo_d     = 1'b0;
                end else if (wr_req) begin
                    wr_go     = 1'b1;
                    state_d   = S_WR;
                    cnt_d     = '0;
                    last_wr_d = 1'b1;
                    tmo_d     = 1'b0;
                end
            end

            S_RD: begin
                SD_MOSI = rd_mosi;
                SD_CSn  = rd_csn;
                // A done coinciding with the last allowed cycle is a clean finish.
                if (rd_done) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_WR: begin
                SD_MOSI = wr_mosi;
                SD_CSn  = wr_csn;
                if (wr_done) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign tmo_err = tmo_q;

endmodule

// File: tb/tb_sd_bus_sched.sv
module tb_sd_bus_sched;

    logic SD_CK = 1'b0;
    logic rst_n;
    logic init_done, init_mosi, init_csn;
    logic rd_req, rd_done, rd_mosi, rd_csn;
    logic wr_req, wr_done, wr_mosi, wr_csn;
    logic init_en, rd_go, wr_go, SD_MOSI, SD_CSn, busy, tmo_err;

    int nvec = 0;
    int nerr = 0;

    sd_bus_sched #(.TIMEOUT_CYC(1024), .GAP_CYC(8)) dut (
        .SD_CK    (SD_CK),
        .rst_n    (rst_n),
        .init_done(init_done),
        .init_mosi(init_mosi),
        .init_csn (init_csn),
        .rd_req   (rd_req),
        .rd_done  (rd_done),
        .rd_mosi  (rd_mosi),
        .rd_csn   (rd_csn),
        .wr_req   (wr_req),
        .wr_done  (wr_done),
        .wr_mosi  (wr_mosi),
        .wr_csn   (wr_csn),
        .init_en  (init_en),
        .rd_go    (rd_go),
        .wr_go    (wr_go),
        .SD_MOSI  (SD_MOSI),
        .SD_CSn   (SD_CSn),
        .busy     (busy),
        .tmo_err  (tmo_err)
    );

    always #5 SD_CK = ~SD_CK;

    task automatic tick();
        @(posedge SD_CK);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init_done = 1'b0; init_mosi = 1'b0; init_csn = 1'b0;
        rd_req = 1'b0; rd_done = 1'b0; rd_mosi = 1'b1; rd_csn = 1'b1;
        wr_req = 1'b0; wr_done = 1'b0; wr_mosi = 1'b1; wr_csn = 1'b1;
        #1;
        nvec++; if (init_en !== 1'b1) begin nerr++; $display("FAIL rst_init_en got %b exp 1", init_en); end
        nvec++; if ({rd_go, wr_go} !== 2'b00) begin nerr++; $display("FAIL rst_go got %b exp 00", {rd_go, wr_go}); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rst_busy got %b exp 1", busy); end
        nvec++; if (tmo_err !== 1'b0) begin nerr++; $display("FAIL rst_tmo got %b exp 0", tmo_err); end
        nvec++; if ({SD_MOSI, SD_CSn} !== 2'b00) begin nerr++; $display("FAIL rst_sd00 got %b exp 00", {SD_MOSI, SD_CSn}); end
        init_mosi = 1'b1; #1;
        nvec++; if ({SD_MOSI, SD_CSn} !== 2'b10) begin nerr++; $display("FAIL rst_sd10 got %b exp 10", {SD_MOSI, SD_CSn}); end
        init_mosi = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        // Reset released at cycle 0; init_done raised in cycle 20.
        for (int i = 1; i < 20; i++) begin
            tick();
            if (init_en !== 1'b1) begin nvec++; nerr++; $display("FAIL init_hold cyc %0d got %b exp 1", i, init_en); end
        end
        tick();
        init_done = 1'b1; #1;
        nvec++; if (init_en !== 1'b1) begin nerr++; $display("FAIL init_c20 got %b exp 1", init_en); end
        tick();
        nvec++; if (init_en !== 1'b0) begin nerr++; $display("FAIL init_c21 got %b exp 0", init_en); end
        init_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            nvec++;
            if ({busy, SD_CSn, SD_MOSI} !== 3'b111) begin
                nerr++; $display("FAIL init_gap k=%0d busy/csn/mosi got %b exp 111", k, {busy, SD_CSn, SD_MOSI});
            end
            tick();
        end
        nvec++; if ({busy, SD_CSn, SD_MOSI, init_en} !== 4'b0110) begin
            nerr++; $display("FAIL init_idle busy/csn/mosi/en got %b exp 0110", {busy, SD_CSn, SD_MOSI, init_en});
        end
    endtask

    task automatic test_round_robin();
        rd_req = 1'b1; wr_req = 1'b1; #1;
        nvec++; if ({rd_go, wr_go} !== 2'b10) begin nerr++; $display("FAIL rr_first got %b exp 10", {rd_go, wr_go}); end
        tick();
        rd_mosi = 1'b0; rd_csn = 1'b0; #1;
        nvec++; if ({rd_go, wr_go, SD_MOSI, SD_CSn, busy} !== 5'b00001) begin
            nerr++; $display("FAIL rr_rd_own got %b exp 00001", {rd_go, wr_go, SD_MOSI, SD_CSn, busy});
        end
        tick(); tick(); tick();
        rd_done = 1'b1; tick(); rd_done = 1'b0; #1;
        for (int k = 0; k < 8; k++) begin
            nvec++;
            if ({rd_go, wr_go, SD_CSn, busy} !== 4'b0011) begin
                nerr++; $display("FAIL rr_gap k=%0d go/csn/busy got %b exp 0011", k, {rd_go, wr_go, SD_CSn, busy});
            end
            tick();
        end
        nvec++; if ({rd_go, wr_go} !== 2'b01) begin nerr++; $display("FAIL rr_second got %b exp 01", {rd_go, wr_go}); end
        tick();
        wr_req = 1'b0; wr_mosi = 1'b0; wr_csn = 1'b0; #1;
        nvec++; if ({SD_MOSI, SD_CSn, rd_go} !== 3'b000) begin
            nerr++; $display("FAIL rr_wr_own got %b exp 000", {SD_MOSI, SD_CSn, rd_go});
        end
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        // Read held through WR and GAP is still pending.
        nvec++; if ({rd_go, wr_go, busy} !== 3'b100) begin
            nerr++; $display("FAIL rr_held got %b exp 100", {rd_go, wr_go, busy});
        end
        rd_req = 1'b0; #1;
        nvec++; if (rd_go !== 1'b0) begin nerr++; $display("FAIL rr_withdraw got %b exp 0", rd_go); end
        tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rr_withdraw_idle got %b exp 0", busy); end
        wr_mosi = 1'b1; wr_csn = 1'b1; rd_mosi = 1'b1; rd_csn = 1'b1;
    endtask

    task automatic test_timeout();
        rd_req = 1'b1; #1;
        nvec++; if (rd_go !== 1'b1) begin nerr++; $display("FAIL tmo_go got %b exp 1", rd_go); end
        tick();
        rd_req = 1'b0; rd_csn = 1'b0;
        for (int i = 1; i < 1024; i++) tick();
        nvec++; if ({SD_CSn, busy, tmo_err} !== 3'b010) begin
            nerr++; $display("FAIL tmo_last_cyc csn/busy/tmo got %b exp 010", {SD_CSn, busy, tmo_err});
        end
        tick();
        nvec++; if ({SD_CSn, tmo_err} !== 2'b11) begin
            nerr++; $display("FAIL tmo_abort csn/tmo got %b exp 11", {SD_CSn, tmo_err});
        end
        for (int k = 0; k < 8; k++) tick();
        nvec++; if ({busy, tmo_err} !== 2'b01) begin
            nerr++; $display("FAIL tmo_sticky busy/tmo got %b exp 01", {busy, tmo_err});
        end
        rd_csn = 1'b1;
        wr_req = 1'b1; #1;
        nvec++; if (wr_go !== 1'b1) begin nerr++; $display("FAIL tmo_wr_go got %b exp 1", wr_go); end
        tick();
        wr_req = 1'b0;
        nvec++; if (tmo_err !== 1'b0) begin nerr++; $display("FAIL tmo_clear got %b exp 0", tmo_err); end
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL tmo_idle got %b exp 0", busy); end
    endtask

    task automatic test_foreign_done();
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        rd_mosi = 1'b1; rd_csn = 1'b0; wr_mosi = 1'b0; wr_csn = 1'b1;
        wr_done = 1'b1; tick(); wr_done = 1'b0; #1;
        nvec++; if ({busy, SD_MOSI, SD_CSn} !== 3'b110) begin
            nerr++; $display("FAIL fd_stay busy/mosi/csn got %b exp 110", {busy, SD_MOSI, SD_CSn});
        end
        rd_mosi = 1'b0; #1;
        nvec++; if ({SD_MOSI, SD_CSn} !== 2'b00) begin
            nerr++; $display("FAIL fd_track mosi/csn got %b exp 00", {SD_MOSI, SD_CSn});
        end
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        nvec++; if ({SD_MOSI, SD_CSn, busy} !== 3'b111) begin
            nerr++; $display("FAIL fd_gap got %b exp 111", {SD_MOSI, SD_CSn, busy});
        end
        for (int k = 0; k < 8; k++) tick();
        rd_mosi = 1'b1; rd_csn = 1'b1; wr_mosi = 1'b1; wr_csn = 1'b1;
    endtask

    task automatic test_done_at_timeout();
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        rd_csn = 1'b0;
        for (int i = 1; i < 1024; i++) tick();
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        nvec++; if ({tmo_err, SD_CSn, busy} !== 3'b011) begin
            nerr++; $display("FAIL dat_tmo tmo/csn/busy got %b exp 011", {tmo_err, SD_CSn, busy});
        end
        for (int k = 0; k < 8; k++) tick();
        nvec++; if ({busy, tmo_err} !== 2'b00) begin
            nerr++; $display("FAIL dat_idle busy/tmo got %b exp 00", {busy, tmo_err});
        end
        rd_csn = 1'b1;
    endtask

    task automatic test_reset_mid_wr();
        wr_req = 1'b1; tick();
        wr_mosi = 1'b1; wr_csn = 1'b0; init_mosi = 1'b0; init_csn = 1'b1; #1;
        nvec++; if ({SD_MOSI, SD_CSn} !== 2'b10) begin
            nerr++; $display("FAIL rmw_wr_own got %b exp 10", {SD_MOSI, SD_CSn});
        end
        #2 rst_n = 1'b0; #1;
        nvec++; if ({SD_MOSI, SD_CSn, init_en, wr_go, tmo_err, busy} !== 6'b011001) begin
            nerr++; $display("FAIL rmw_abort mosi/csn/en/go/tmo/busy got %b exp 011001",
                             {SD_MOSI, SD_CSn, init_en, wr_go, tmo_err, busy});
        end
        tick();
        rst_n = 1'b1;
        tick();
        nvec++; if ({init_en, wr_go, rd_go, tmo_err} !== 4'b1000) begin
            nerr++; $display("FAIL rmw_after got %b exp 1000", {init_en, wr_go, rd_go, tmo_err});
        end
        wr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_round_robin();
        test_timeout();
        test_foreign_done();
        test_done_at_timeout();
        test_reset_mid_wr();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
